// File: rtl/shared_bus_arbiter_if.sv
// Request/grant bundle between the shared data-bus devices and the bus arbiter.
// The master modport is the arbiter side; the slave modport is the device/bus side.
interface shared_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic             bus_valid;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             bus_busy;
    logic             timeout_err;
    logic             proto_err;

    modport master (
        input  req,
        input  bus_valid,
        output grant,
        output grant_id,
        output bus_busy,
        output timeout_err,
        output proto_err
    );

    modport slave (
        output req,
        output bus_valid,
        input  grant,
        input  grant_id,
        input  bus_busy,
        input  timeout_err,
        input  proto_err
    );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner arbiter for the shared 8-bit tri-state data bus.
// It limits burst length, revokes silent owners, and forces one turnaround cycle between owners.
//
// state | meaning
// IDLE  | no owner, no pending turnaround; first request seen is granted next cycle
// GRANT | one device owns the bus; beat/idle counters run, release checks active
// TURN  | grant forced low for one cycle after a release; re-arbitrates if requests pend
module shared_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    shared_bus_arbiter_if.master bus
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic [7:0]       idle_cnt_q, idle_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             proto_err_q;
    logic             bus_busy_q;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [IDW:0]     scan_sum;
    logic [IDW-1:0]   scan_idx;

    logic             rel_drop;
    logic             rel_burst;
    logic             rel_timeout;
    logic [IDW-1:0]   owner_next;

    // Search starts at rr_ptr and wraps; the first requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (scan_sum >= (IDW+1)'(N_REQ)) begin
                scan_sum = scan_sum - (IDW+1)'(N_REQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    assign rel_drop    = !bus.req[owner_q];
    assign rel_burst   = bus.bus_valid && (beat_cnt_q == 8'(MAX_BURST - 1));
    assign rel_timeout = !bus.bus_valid && (idle_cnt_q == 8'(TIMEOUT - 1));
    assign owner_next  = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE, TURN: begin
                grant_d = '0;
                if (win_found) begin
                    state_d         = GRANT;
                    grant_d[win_id] = 1'b1;
                    owner_d         = win_id;
                    beat_cnt_d      = '0;
                    idle_cnt_d      = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            GRANT: begin
                if (bus.bus_valid) begin
                    idle_cnt_d = '0;
                    if (beat_cnt_q != 8'hFF) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end else if (idle_cnt_q != 8'hFF) begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end

                // A voluntary drop in the same cycle masks the timeout report.
                if (rel_drop || rel_burst || rel_timeout) begin
                    state_d       = TURN;
                    grant_d       = '0;
                    rr_ptr_d      = owner_next;
                    timeout_err_d = rel_timeout && !rel_drop;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
            bus_busy_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= bus.bus_valid && (grant_q == '0);
            bus_busy_q    <= |grant_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = owner_q;
    assign bus.bus_busy    = bus_busy_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.proto_err   = proto_err_q;
endmodule
